// File: rtl/instr_reg_decode_pkg.sv
// -----------------------------------------------------------------------------
// instr_reg_decode_pkg
//   Shared definitions for the instruction register / field decode block and
//   for any control logic that needs the same view of the instruction word.
//
//   Contents:
//     - MIPS primary opcode constants (OP_*)
//     - ext_mode_t : immediate-extender select codes (EXT_*)
//     - fetch_state_t : fetch FSM state encoding
//     - instr_fields_t : packed overlay of a 32-bit word onto its fields
// -----------------------------------------------------------------------------
package instr_reg_decode_pkg;

  // Primary opcodes (instr[31:26]) that the extender decode cares about.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Immediate extender select.
  //   SIGN  : sign-extend imm16
  //   ZERO  : zero-extend imm16 (logical immediates)
  //   UPPER : imm16 placed in the upper half (lui)
  //   WORD  : word-shifted jump target (j/jal)
  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_WORD  = 2'b11
  } ext_mode_t;

  // Fetch FSM: idle, or waiting on instruction memory.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_t;

  // Field overlay of an instruction word; the first member lands on the MSBs,
  // so a straight cast of the 32-bit word yields the R-format fields.
  typedef struct packed {
    logic [5:0] opcode;  // [31:26]
    logic [4:0] rs;      // [25:21]
    logic [4:0] rt;      // [20:16]
    logic [4:0] rd;      // [15:11]
    logic [4:0] shamt;   // [10:6]
    logic [5:0] funct;   // [5:0]
  } instr_fields_t;

endpackage : instr_reg_decode_pkg

// File: rtl/instr_reg_decode_ext_mode_decode.sv
// -----------------------------------------------------------------------------
// ext_mode_decode
//   Pure combinational opcode -> immediate-extender select. Kept as its own
//   module so the main control unit can reuse exactly the same mapping.
//
//   Ports:
//     opcode   in  6  primary opcode (instr[31:26])
//     ext_mode out 2  extender select (see ext_mode_t)
// -----------------------------------------------------------------------------
module ext_mode_decode
  import instr_reg_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] ext_mode
);

  ext_mode_t mode;

  always_comb begin
    // NOTE: default assignment first so every path drives mode -> no latch.
    mode = EXT_SIGN;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI:            mode = EXT_ZERO;
      OP_LUI:                              mode = EXT_UPPER;
      OP_J, OP_JAL:                        mode = EXT_WORD;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_RTYPE:                            mode = EXT_SIGN;
      default:                             mode = EXT_SIGN;
    endcase
  end

  assign ext_mode = mode;

endmodule : ext_mode_decode

// File: rtl/instr_reg_decode.sv
// -----------------------------------------------------------------------------
// instr_reg_decode
//   Instruction register plus field decode for the multi-cycle MIPS datapath.
//   On an ir_write request it fetches one word from instruction memory over a
//   req/valid handshake, holds it in the IR until the next successful fetch,
//   and splits it into fields. imm16 and ext_mode feed the immediate extender.
//
//   Parameters:
//     MEM_TIMEOUT  cycles to wait for mem_valid after mem_req (0 = forever)
//     RESET_INSTR  IR contents after reset
//
//   Ports:
//     clk          in   1   rising-edge clock
//     reset        in   1   asynchronous, active-high
//     ir_write     in   1   fetch request from the control FSM (pulse or level)
//     mem_rdata    in   32  instruction memory read data
//     mem_valid    in   1   mem_rdata is valid this cycle
//     mem_req      out  1   fetch request, held until mem_valid or timeout
//     busy         out  1   fetch in progress
//     instr_valid  out  1   one-cycle pulse: IR updated
//     fetch_err    out  1   one-cycle pulse: fetch timed out, IR unchanged
//     instr        out  32  IR contents
//     opcode..funct         instruction fields, combinational from IR
//     imm16        out  16  instr[15:0], extender data input
//     ext_mode     out  2   extender select, combinational from IR opcode
// -----------------------------------------------------------------------------
module instr_reg_decode
  import instr_reg_decode_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        mem_req,
  output logic        busy,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [1:0]  ext_mode
);

  // Counter wide enough to hold MEM_TIMEOUT; one bit minimum so the
  // "wait forever" configuration still elaborates.
  localparam int unsigned CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fetch_state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      ir;
  instr_fields_t    fields;

  // ---------------------------------------------------------------------------
  // Fetch FSM, timeout counter and IR. All outputs of this block are
  // registered; the pulses default low each cycle and are raised for exactly
  // one cycle on the transition back to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      // NOTE: the IR is reset (not left X) because the field decode and the
      // extender downstream are live from the first cycle out of reset.
      ir          <= RESET_INSTR;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values of the others regardless of statement order.
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          // mem_valid is ignored here: nothing outstanding, IR stays put.
          if (ir_write) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_REQ: begin
          // ir_write is ignored while a fetch is outstanding. Data is checked
          // before the timeout so a word arriving on the expiry cycle wins.
          if (mem_valid) begin
            ir          <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= S_IDLE;
          end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state     <= S_IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Field split and extender select, straight from the IR (no added latency).
  // ---------------------------------------------------------------------------
  assign fields = instr_fields_t'(ir);
  assign instr  = ir;
  assign opcode = fields.opcode;
  assign rs     = fields.rs;
  assign rt     = fields.rt;
  assign rd     = fields.rd;
  assign shamt  = fields.shamt;
  assign funct  = fields.funct;
  assign imm16  = ir[15:0];

  ext_mode_decode u_ext_mode_decode (
    .opcode   (fields.opcode),
    .ext_mode (ext_mode)
  );

endmodule : instr_reg_decode
